// File: rtl/wb.sv
// ---------------------------------------------------------------------------
// wb : write-back stage accumulator pair with forwarding.
//
// A MEM-stage beat (data + 3-bit command) is sampled on the rising clock edge
// when iValid_MEM is high. Its effect shows on the outputs one cycle later.
// Command 100 splits a write across two beats: the first beat loads B and
// parks the FSM in PAIR_HI. The next valid beat with code 100 then loads A.
//
// Ports
//   Clock            : single clock, rising-edge active
//   Reset            : synchronous, active-high
//   iDataFromMEM     : data beat (WIDTH bits)
//   iControlAcum_MEM : accumulator write command (3 bits)
//   iValid_MEM       : beat qualifier
//   oAcumA / oAcumB  : registered accumulator contents
//   oForwardData     : last value written to any accumulator (held)
//   oForwardValid    : one-cycle pulse qualifying oForwardData
//   oPairPending     : high while waiting for the high half of a pair
//   oError           : one-cycle pulse on reserved command or broken pair
//   oWriteCount      : completed writes, saturating at 255
// ---------------------------------------------------------------------------
module wb #(
  parameter int WIDTH = 8
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [WIDTH-1:0] iDataFromMEM,
  input  logic [2:0]       iControlAcum_MEM,
  input  logic             iValid_MEM,
  output logic [WIDTH-1:0] oAcumA,
  output logic [WIDTH-1:0] oAcumB,
  output logic [WIDTH-1:0] oForwardData,
  output logic             oForwardValid,
  output logic             oPairPending,
  output logic             oError,
  output logic [7:0]       oWriteCount
);

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    PAIR_HI = 1'b1
  } state_e;

  localparam logic [2:0] CMD_NOP   = 3'b000;
  localparam logic [2:0] CMD_WR_A  = 3'b001;
  localparam logic [2:0] CMD_WR_B  = 3'b010;
  localparam logic [2:0] CMD_WR_AB = 3'b011;
  localparam logic [2:0] CMD_PAIR  = 3'b100;
  localparam logic [2:0] CMD_CLR_A = 3'b101;
  localparam logic [2:0] CMD_CLR_B = 3'b110;
  localparam logic [2:0] CMD_RSVD  = 3'b111;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acum_a_q, acum_a_d;
  logic [WIDTH-1:0] acum_b_q, acum_b_d;
  logic [WIDTH-1:0] fwd_data_q, fwd_data_d;
  logic             fwd_vld_q, fwd_vld_d;
  logic             err_q, err_d;
  logic [7:0]       wr_cnt_q, wr_cnt_d;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Next-state: decode the sampled beat against the current FSM state
  always_comb begin
    state_d    = state_q;
    acum_a_d   = acum_a_q;
    acum_b_d   = acum_b_q;
    fwd_data_d = fwd_data_q;
    fwd_vld_d  = 1'b0;
    err_d      = 1'b0;
    wr_cnt_d   = wr_cnt_q;

    if (iValid_MEM) begin
      if (state_q == PAIR_HI && iControlAcum_MEM == CMD_PAIR) begin
        // High half completes the pair; the pair counts as a single write.
        acum_a_d   = iDataFromMEM;
        fwd_data_d = iDataFromMEM;
        fwd_vld_d  = 1'b1;
        wr_cnt_d   = sat_inc(wr_cnt_q);
        state_d    = IDLE;
      end else begin
        // Any other beat in PAIR_HI breaks the pair: flag it, then run the
        // beat as an ordinary IDLE beat. B keeps the low half already loaded.
        if (state_q == PAIR_HI) begin
          err_d = 1'b1;
        end
        state_d = IDLE;
        unique case (iControlAcum_MEM)
          CMD_NOP: ;
          CMD_WR_A: begin
            acum_a_d   = iDataFromMEM;
            fwd_data_d = iDataFromMEM;
            fwd_vld_d  = 1'b1;
            wr_cnt_d   = sat_inc(wr_cnt_q);
          end
          CMD_WR_B: begin
            acum_b_d   = iDataFromMEM;
            fwd_data_d = iDataFromMEM;
            fwd_vld_d  = 1'b1;
            wr_cnt_d   = sat_inc(wr_cnt_q);
          end
          CMD_WR_AB: begin
            acum_a_d   = iDataFromMEM;
            acum_b_d   = iDataFromMEM;
            fwd_data_d = iDataFromMEM;
            fwd_vld_d  = 1'b1;
            wr_cnt_d   = sat_inc(wr_cnt_q);
          end
          CMD_PAIR: begin
            // Low half only: no forward pulse and no count until completion.
            acum_b_d = iDataFromMEM;
            state_d  = PAIR_HI;
          end
          CMD_CLR_A: begin
            acum_a_d   = '0;
            fwd_data_d = '0;
            fwd_vld_d  = 1'b1;
            wr_cnt_d   = sat_inc(wr_cnt_q);
          end
          CMD_CLR_B: begin
            acum_b_d   = '0;
            fwd_data_d = '0;
            fwd_vld_d  = 1'b1;
            wr_cnt_d   = sat_inc(wr_cnt_q);
          end
          CMD_RSVD: begin
            err_d = 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  // Register stage: reset overrides any beat sampled on the same edge
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q    <= IDLE;
      acum_a_q   <= '0;
      acum_b_q   <= '0;
      fwd_data_q <= '0;
      fwd_vld_q  <= 1'b0;
      err_q      <= 1'b0;
      wr_cnt_q   <= 8'd0;
    end else begin
      state_q    <= state_d;
      acum_a_q   <= acum_a_d;
      acum_b_q   <= acum_b_d;
      fwd_data_q <= fwd_data_d;
      fwd_vld_q  <= fwd_vld_d;
      err_q      <= err_d;
      wr_cnt_q   <= wr_cnt_d;
    end
  end

  assign oAcumA        = acum_a_q;
  assign oAcumB        = acum_b_q;
  assign oForwardData  = fwd_data_q;
  assign oForwardValid = fwd_vld_q;
  assign oPairPending  = (state_q == PAIR_HI);
  assign oError        = err_q;
  assign oWriteCount   = wr_cnt_q;

endmodule

// File: tb/tb_wb.sv
module tb_wb;

  localparam int W = 8;

  logic         Clock = 1'b0;
  logic         Reset = 1'b1;
  logic [W-1:0] iDataFromMEM = '0;
  logic [2:0]   iControlAcum_MEM = 3'b000;
  logic         iValid_MEM = 1'b0;
  logic [W-1:0] oAcumA, oAcumB, oForwardData;
  logic         oForwardValid, oPairPending, oError;
  logic [7:0]   oWriteCount;

  wb #(.WIDTH(W)) dut (
    .Clock            (Clock),
    .Reset            (Reset),
    .iDataFromMEM     (iDataFromMEM),
    .iControlAcum_MEM (iControlAcum_MEM),
    .iValid_MEM       (iValid_MEM),
    .oAcumA           (oAcumA),
    .oAcumB           (oAcumB),
    .oForwardData     (oForwardData),
    .oForwardValid    (oForwardValid),
    .oPairPending     (oPairPending),
    .oError           (oError),
    .oWriteCount      (oWriteCount)
  );

  always #5 Clock = ~Clock;

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] fd;
    logic         fv;
    logic         pp;
    logic         er;
    logic [7:0]   wc;
  } exp_t;

  exp_t exp_q[$];

  // Reference model state
  logic [W-1:0] m_a = '0, m_b = '0, m_fd = '0;
  logic [7:0]   m_wc = 8'd0;
  logic         m_pair = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  // Per-scenario tallies of observed DUT outputs
  int fwd_pulses, pair_cycles, err_pulses;
  logic [W-1:0] fwd_seen [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_tally();
    fwd_pulses  = 0;
    pair_cycles = 0;
    err_pulses  = 0;
    fwd_seen.delete();
  endtask

  // Advance the model by one beat and push the expected post-edge outputs
  task automatic model_push(input logic rst, input logic v, input logic [2:0] c,
                            input logic [W-1:0] d);
    exp_t e;
    logic fv, er;
    fv = 1'b0;
    er = 1'b0;
    if (rst) begin
      m_a = '0; m_b = '0; m_fd = '0; m_wc = 8'd0; m_pair = 1'b0;
    end else if (v) begin
      if (m_pair && c == 3'b100) begin
        m_a = d; m_fd = d; fv = 1'b1; m_pair = 1'b0;
      end else begin
        if (m_pair) er = 1'b1;
        m_pair = 1'b0;
        if (c == 3'b001) begin m_a = d; m_fd = d; fv = 1'b1; end
        if (c == 3'b010) begin m_b = d; m_fd = d; fv = 1'b1; end
        if (c == 3'b011) begin m_a = d; m_b = d; m_fd = d; fv = 1'b1; end
        if (c == 3'b100) begin m_b = d; m_pair = 1'b1; end
        if (c == 3'b101) begin m_a = '0; m_fd = '0; fv = 1'b1; end
        if (c == 3'b110) begin m_b = '0; m_fd = '0; fv = 1'b1; end
        if (c == 3'b111) er = 1'b1;
      end
      if (fv && m_wc != 8'd255) m_wc = m_wc + 8'd1;
    end
    e.a = m_a; e.b = m_b; e.fd = m_fd; e.fv = fv;
    e.pp = m_pair; e.er = er; e.wc = m_wc;
    exp_q.push_back(e);
  endtask

  task automatic step(input logic rst, input logic v, input logic [2:0] c,
                      input logic [W-1:0] d);
    exp_t e;
    @(negedge Clock);
    Reset            = rst;
    iValid_MEM       = v;
    iControlAcum_MEM = c;
    iDataFromMEM     = d;
    model_push(rst, v, c, d);
    @(posedge Clock);
    #1;
    if (exp_q.size() == 0) begin
      chk("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      chk("acum_a",     32'(oAcumA),        32'(e.a));
      chk("acum_b",     32'(oAcumB),        32'(e.b));
      chk("fwd_data",   32'(oForwardData),  32'(e.fd));
      chk("fwd_valid",  32'(oForwardValid), 32'(e.fv));
      chk("pair_pend",  32'(oPairPending),  32'(e.pp));
      chk("error",      32'(oError),        32'(e.er));
      chk("write_cnt",  32'(oWriteCount),   32'(e.wc));
    end
    if (oForwardValid === 1'b1) begin
      fwd_pulses++;
      fwd_seen.push_back(oForwardData);
    end
    if (oPairPending === 1'b1) pair_cycles++;
    if (oError === 1'b1) err_pulses++;
    Reset      = 1'b0;
    iValid_MEM = 1'b0;
  endtask

  initial begin
    // Reset state
    step(1'b1, 1'b0, 3'b000, 8'h00);
    chk("rst_a",   32'(oAcumA), 32'h0);
    chk("rst_wc",  32'(oWriteCount), 32'h0);
    chk("rst_pp",  32'(oPairPending), 32'h0);

    // Basic writes
    clear_tally();
    step(1'b0, 1'b1, 3'b001, 8'h09);
    step(1'b0, 1'b1, 3'b010, 8'h08);
    step(1'b0, 1'b0, 3'b000, 8'h00);
    chk("basic_a",      32'(oAcumA), 32'h09);
    chk("basic_b",      32'(oAcumB), 32'h08);
    chk("basic_fwd_n",  32'(fwd_pulses), 32'd2);
    chk("basic_fwd_0",  32'(fwd_seen[0]), 32'h09);
    chk("basic_fwd_1",  32'(fwd_seen[1]), 32'h08);
    chk("basic_wc",     32'(oWriteCount), 32'd2);
    chk("basic_fd_hold",32'(oForwardData), 32'h08);

    // Clears and NOP
    step(1'b0, 1'b1, 3'b101, 8'hEE);
    step(1'b0, 1'b1, 3'b000, 8'h77);
    step(1'b0, 1'b1, 3'b110, 8'h33);
    chk("clr_a", 32'(oAcumA), 32'h0);
    chk("clr_b", 32'(oAcumB), 32'h0);
    chk("clr_wc", 32'(oWriteCount), 32'd4);

    // Pair with a gap
    step(1'b1, 1'b0, 3'b000, 8'h00);
    clear_tally();
    step(1'b0, 1'b1, 3'b100, 8'h34);
    step(1'b0, 1'b0, 3'b100, 8'hAB);
    step(1'b0, 1'b0, 3'b001, 8'hCD);
    step(1'b0, 1'b0, 3'b000, 8'h00);
    step(1'b0, 1'b1, 3'b100, 8'h12);
    step(1'b0, 1'b0, 3'b000, 8'h00);
    chk("pair_b",      32'(oAcumB), 32'h34);
    chk("pair_a",      32'(oAcumA), 32'h12);
    chk("pair_cycles", 32'(pair_cycles), 32'd4);
    chk("pair_fwd_n",  32'(fwd_pulses), 32'd1);
    chk("pair_fwd_0",  32'(fwd_seen[0]), 32'h12);
    chk("pair_wc",     32'(oWriteCount), 32'd1);

    // Broken pair
    clear_tally();
    step(1'b0, 1'b1, 3'b100, 8'h0F);
    step(1'b0, 1'b1, 3'b001, 8'h07);
    chk("brk_err",  32'(err_pulses), 32'd1);
    chk("brk_a",    32'(oAcumA), 32'h07);
    chk("brk_b",    32'(oAcumB), 32'h0F);
    chk("brk_idle", 32'(oPairPending), 32'd0);
    chk("brk_wc",   32'(oWriteCount), 32'd2);

    // Reserved command
    clear_tally();
    step(1'b0, 1'b1, 3'b111, 8'hFF);
    step(1'b0, 1'b0, 3'b000, 8'h00);
    chk("rsv_err",   32'(err_pulses), 32'd1);
    chk("rsv_a",     32'(oAcumA), 32'h07);
    chk("rsv_b",     32'(oAcumB), 32'h0F);
    chk("rsv_wc",    32'(oWriteCount), 32'd2);
    chk("rsv_fwd_n", 32'(fwd_pulses), 32'd0);

    // Counter saturation
    step(1'b1, 1'b0, 3'b000, 8'h00);
    for (int i = 0; i < 300; i++) begin
      step(1'b0, 1'b1, 3'b011, 8'(i));
    end
    chk("sat_wc", 32'(oWriteCount), 32'd255);
    chk("sat_a",  32'(oAcumA), 32'h2B);
    chk("sat_b",  32'(oAcumB), 32'h2B);

    // Reset mid-pair
    clear_tally();
    step(1'b0, 1'b1, 3'b100, 8'hAA);
    chk("mid_pp", 32'(oPairPending), 32'd1);
    step(1'b1, 1'b1, 3'b100, 8'h55);
    chk("mid_a",  32'(oAcumA), 32'h0);
    chk("mid_b",  32'(oAcumB), 32'h0);
    chk("mid_fd", 32'(oForwardData), 32'h0);
    chk("mid_wc", 32'(oWriteCount), 32'h0);
    chk("mid_pp_clr", 32'(oPairPending), 32'd0);
    step(1'b0, 1'b0, 3'b000, 8'h00);
    chk("mid_err", 32'(err_pulses), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
